// File: rtl/fp_addsub_pkg.sv
// Shared widths and the result record for the FP add/sub normalization stages.
// The register struct is sized by the DEF_* widths below. Modules that carry
// norm2_res_t must be built with matching parameter values.
package fp_addsub_pkg;

  localparam int DEF_MAN_W   = 4;
  localparam int DEF_EXP_W   = 3;
  localparam int DEF_SHIFT_W = 3;
  localparam int DEF_STK_W   = 3;
  localparam int DEF_SUM_W   = DEF_MAN_W + 2 + DEF_STK_W;

  // Normalize-shift-2 result, used as the S1 and S2 pipeline register type.
  typedef struct packed {
    logic [DEF_MAN_W-1:0] normm;
    logic [DEF_EXP_W:0]   norme;
    logic                 zero;
    logic                 nege;
    logic                 ovfe;
    logic                 fg;
    logic                 r;
    logic                 s;
  } norm2_res_t;

endpackage

// File: rtl/fp_norm2_calc.sv
// Combinational calculation for normalize-shift stage 2.
// The mantissa comes from the top MAN_W bits of the pre-shift sum, and the
// guard (fg), round (r) and sticky (s) bits come from the bits below them.
// The exponent is cexp - shift + carry-out bit of the sum.
// Optional macro FP_NORM_EXP_SAT_EN: the exponent is computed with headroom.
// A negative result clamps to 0 with nege=1. A result >= 2**EXP_W raises ovfe.
// Without the macro the exponent wraps modulo 2**(EXP_W+1), and its top bit is
// reported as nege.
module fp_norm2_calc
  import fp_addsub_pkg::*;
#(
  parameter int MAN_W   = DEF_MAN_W,
  parameter int EXP_W   = DEF_EXP_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int STK_W   = DEF_STK_W,
  localparam int SUM_W  = MAN_W + 2 + STK_W
) (
  input  logic [SUM_W-1:0]   pssum,
  input  logic [EXP_W-1:0]   cexp,
  input  logic [SHIFT_W-1:0] shift,
  output norm2_res_t         res
);

  localparam int EW1 = EXP_W + 1;

`ifdef FP_NORM_EXP_SAT_EN
  localparam int EW2 = EXP_W + 2;

  // With two extra bits the top bit is the sign. For a non-negative value,
  // bit EXP_W set means the value is >= 2**EXP_W.
  logic [EW2-1:0] e_sat;
  assign e_sat = EW2'(cexp) - EW2'(shift) + EW2'(pssum[SUM_W-1]);
`else
  logic [EW1-1:0] e_wrap;
  assign e_wrap = EW1'(cexp) - EW1'(shift) + EW1'(pssum[SUM_W-1]);
`endif

  // Assemble the result record from the sum fields and the adjusted exponent.
  always_comb begin
    res       = '0;
    res.normm = pssum[SUM_W-1 -: MAN_W];
    res.fg    = pssum[STK_W+1];
    res.r     = pssum[STK_W];
    res.s     = |pssum[STK_W-1:0];
    res.zero  = ~|pssum;
`ifdef FP_NORM_EXP_SAT_EN
    if (e_sat[EW2-1]) begin
      res.norme = '0;
      res.nege  = 1'b1;
      res.ovfe  = 1'b0;
    end else begin
      res.norme = e_sat[EW1-1:0];
      res.nege  = 1'b0;
      res.ovfe  = e_sat[EXP_W];
    end
`else
    res.norme = e_wrap;
    res.nege  = e_wrap[EXP_W];
    res.ovfe  = 1'b0;
`endif
  end

endmodule

// File: rtl/fp_normalize_shift2_pipe.sv
// Normalize-shift stage 2 of the FP add/sub datapath. It sits between
// NormalizeShift1 and Round.
// The stage has two register stages: S1 holds the calculated result and S2 is
// the output register. Latency is 2 cycles and throughput is 1 beat per cycle.
// Optional macro FP_NORM_EXP_SAT_EN selects exponent saturation inside
// fp_norm2_calc.
//
// Handshake: a beat moves on an edge where valid and ready are both high.
// A producer holds valid and data steady until the beat is accepted.
// out_valid and the out_* fields stay stable while out_ready is low.
// in_ready depends combinationally on out_ready. There is no skid buffer, so
// a full stall holds exactly two beats.
module fp_normalize_shift2_pipe
  import fp_addsub_pkg::*;
#(
  parameter int MAN_W   = DEF_MAN_W,
  parameter int EXP_W   = DEF_EXP_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int STK_W   = DEF_STK_W,
  localparam int SUM_W  = MAN_W + 2 + STK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SUM_W-1:0]   in_pssum,
  input  logic [EXP_W-1:0]   in_cexp,
  input  logic [SHIFT_W-1:0] in_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MAN_W-1:0]   out_normm,
  output logic [EXP_W:0]     out_norme,
  output logic               out_zero,
  output logic               out_nege,
  output logic               out_ovfe,
  output logic               out_fg,
  output logic               out_r,
  output logic               out_s
);

  norm2_res_t calc_res;
  norm2_res_t s1_data;
  norm2_res_t s2_data;
  logic       s1_valid;
  logic       s2_valid;
  logic       s2_load;
  logic       s1_adv;

  fp_norm2_calc #(
    .MAN_W   (MAN_W),
    .EXP_W   (EXP_W),
    .SHIFT_W (SHIFT_W),
    .STK_W   (STK_W)
  ) u_calc (
    .pssum (in_pssum),
    .cexp  (in_cexp),
    .shift (in_shift),
    .res   (calc_res)
  );

  // Advance rules: S2 takes a new beat when it is empty or being drained.
  // S1 accepts input when it is empty or moving into S2.
  always_comb begin
    s2_load  = !s2_valid || out_ready;
    s1_adv   = s1_valid && s2_load;
    in_ready = !s1_valid || s1_adv;
  end

  // S1 register: latches the calculated result of an accepted input beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= calc_res;
      end
    end
  end

  // S2 register: the output stage. It keeps its contents while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= s1_data;
      end
    end
  end

  // Drive the output ports from the S2 register fields.
  always_comb begin
    out_valid = s2_valid;
    out_normm = s2_data.normm;
    out_norme = s2_data.norme;
    out_zero  = s2_data.zero;
    out_nege  = s2_data.nege;
    out_ovfe  = s2_data.ovfe;
    out_fg    = s2_data.fg;
    out_r     = s2_data.r;
    out_s     = s2_data.s;
  end

endmodule

// File: tb/tb_fp_normalize_shift2_pipe.sv
// Directed testbench for fp_normalize_shift2_pipe at the default widths.
// Result words are packed as {normm, norme, zero, nege, ovfe, fg, r, s}.
module tb_fp_normalize_shift2_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_pssum;
  logic [2:0] in_cexp;
  logic [2:0] in_shift;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_normm;
  logic [3:0] out_norme;
  logic       out_zero;
  logic       out_nege;
  logic       out_ovfe;
  logic       out_fg;
  logic       out_r;
  logic       out_s;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];

  // Directed vectors with hand-computed results.
  logic [8:0]  v_pssum [0:5] = '{9'h1A5, 9'h000, 9'h0F0, 9'h100, 9'h1FF, 9'h00F};
  logic [2:0]  v_cexp  [0:5] = '{3'd3, 3'd5, 3'd1, 3'd7, 3'd0, 3'd7};
  logic [2:0]  v_shift [0:5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd7};
`ifdef FP_NORM_EXP_SAT_EN
  logic [13:0] v_exp [0:5] = '{{4'hD, 4'd3, 6'b000001},
                               {4'h0, 4'd3, 6'b100000},
                               {4'h7, 4'h0, 6'b010100},
                               {4'h8, 4'h8, 6'b001000},
                               {4'hF, 4'd1, 6'b000111},
                               {4'h0, 4'd0, 6'b000011}};
`else
  logic [13:0] v_exp [0:5] = '{{4'hD, 4'd3, 6'b000001},
                               {4'h0, 4'd3, 6'b100000},
                               {4'h7, 4'hE, 6'b010100},
                               {4'h8, 4'h8, 6'b010000},
                               {4'hF, 4'd1, 6'b000111},
                               {4'h0, 4'd0, 6'b000011}};
`endif

  fp_normalize_shift2_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pssum  (in_pssum),
    .in_cexp   (in_cexp),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_normm (out_normm),
    .out_norme (out_norme),
    .out_zero  (out_zero),
    .out_nege  (out_nege),
    .out_ovfe  (out_ovfe),
    .out_fg    (out_fg),
    .out_r     (out_r),
    .out_s     (out_s)
  );

  // Clock and reset
  always #5 clk = ~clk;

  function automatic logic [13:0] got_word();
    return {out_normm, out_norme, out_zero, out_nege, out_ovfe, out_fg, out_r, out_s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: present one beat. Acceptance happens at the next rising edge.
  task automatic drive_beat(input logic [8:0] p, input logic [2:0] c, input logic [2:0] s);
    in_valid = 1'b1;
    in_pssum = p;
    in_cexp  = c;
    in_shift = s;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_pssum = '0; in_cexp = '0; in_shift = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (got_word() !== 14'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", got_word());
    end
  endtask

  task automatic test_vectors();
    logic [13:0] e;
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'b1;
      drive_beat(v_pssum[i], v_cexp[i], v_shift[i]);
      exp_q.push_back(v_exp[i]);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL vec%0d_in_ready got %b want 1", i, in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL vec%0d_latency1 out_valid got %b want 0", i, out_valid);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL vec%0d_latency2 out_valid got %b want 1", i, out_valid);
      end
      checks++;
      if (got_word() !== e) begin
        errors++; $display("FAIL vec%0d_result got %h want %h", i, got_word(), e);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int gaps = 0;
    bit started = 1'b0;
    bit acc;
    logic [13:0] e;
    exp_q.delete();
    for (int c = 0; c < 40 && got < 6; c++) begin
      out_ready = (c >= 5);
      if (sent < 6) begin
        drive_beat(9'h100 | 9'(sent << 5), 3'd4, 3'd1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 4) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2) begin
          errors++; $display("FAIL stall_full in_ready %b accepted %0d want 0 and 2", in_ready, sent);
        end
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0 || got_word() !== exp_q[0]) begin
          errors++; $display("FAIL stall_hold c%0d valid %b word %h", c, out_valid, got_word());
        end
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 14'h3FFF;
        checks++;
        if (got_word() !== e) begin
          errors++; $display("FAIL b2b_beat%0d got %h want %h", got, got_word(), e);
        end
        got++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back({4'(8 + sent), 4'd4, 6'b000000});
        sent++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 6) begin
      errors++; $display("FAIL b2b_count got %0d want 6", got);
    end
    checks++;
    if (gaps != 0) begin
      errors++; $display("FAIL b2b_gaps got %0d want 0", gaps);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    out_ready = 1'b0;
    drive_beat(v_pssum[0], v_cexp[0], v_shift[0]);
    tick();
    drive_beat(v_pssum[4], v_cexp[4], v_shift[4]);
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_full valid %b ready %b want 1 0", out_valid, in_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_flags valid %b ready %b want 0 1", out_valid, in_ready);
    end
    checks++;
    if (got_word() !== 14'h0) begin
      errors++; $display("FAIL midrst_outputs got %h want 0", got_word());
    end
    drive_beat(v_pssum[0], v_cexp[0], v_shift[0]);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_latency1 out_valid got %b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || got_word() !== v_exp[0]) begin
      errors++; $display("FAIL midrst_latency2 valid %b word %h want 1 %h", out_valid, got_word(), v_exp[0]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
